timer_sched: RTL and testbench
==============================

# timer_sched

Round-robin scheduler that shares one `timer` instance (two-stage `div_a`/`div_b` down-counter with resynchronised `start` and a pulsed `timer_it`) among `N_REQ` requesters. Each requester asks for a one-shot delay with its own divider pair. The block arbitrates, loads and starts the timer, and waits for expiry under a watchdog. It then returns a `done` or `err` pulse to the granted requester. It sits between the requesting subsystems and the timer instance, and drives all timer inputs.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `A_WIDTH`, 4: width of the `div_a` field; must match the timer.
- `B_WIDTH`, 4: width of the `div_b` field; must match the timer.
- `WDOG_WIDTH`, 10: watchdog counter width; the timeout is 2^WDOG_WIDTH-1 cycles.
- `clk`  in  1  clock, rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request level.
- `req_div_a`  in  N_REQ*A_WIDTH  per-requester `div_a`; requester i uses slice [i*A_WIDTH +: A_WIDTH].
- `req_div_b`  in  N_REQ*B_WIDTH  per-requester `div_b`; same slicing as `req_div_a`.
- `gnt`  out  N_REQ  one-hot grant, held for the whole service.
- `done`  out  N_REQ  one-cycle pulse: timer expired for this requester.
- `err`  out  N_REQ  one-cycle pulse: zero divider or watchdog timeout.
- `busy`  out  1  high in every state except IDLE.
- `tmr_enable`  out  1  drives timer `enable`.
- `tmr_start`  out  1  drives timer `start`.
- `tmr_div_a`  out  A_WIDTH  drives timer `div_a`.
- `tmr_div_b`  out  B_WIDTH  drives timer `div_b`.
- `tmr_it`  in  1  timer `timer_it` pulse.

## Operation
- **Reset values.** All outputs are registered and reset to 0. The FSM resets to IDLE. The round-robin pointer resets to N_REQ-1, so requester 0 wins first.
- **FSM states and transitions:**
  - IDLE: if any `req` is high, pick the winner, register `gnt`, and go to LOAD.
  - LOAD: latch the winner's dividers into `tmr_div_a`/`tmr_div_b` and assert `tmr_enable`.
    - If either divider is 0, go to FINISH with the err flag set. The timer is never started.
    - Otherwise go to START.
  - START: hold `tmr_start`=1 for 2 cycles, then go to WAIT.
  - WAIT: `tmr_start`=0. The watchdog clears on entry and counts each cycle.
    - `tmr_it`=1: go to FINISH with the done flag.
    - Watchdog reaches all-ones: go to FINISH with the err flag.
  - FINISH (1 cycle): pulse `done[i]` or `err[i]`, clear `gnt` and `tmr_enable`, set the pointer to i, and go to IDLE.
- **Arbitration.** Search starts at pointer+1, modulo N_REQ. Only the pointer and `gnt` are stored; selection is combinational in IDLE.
- **Requester protocol.**
  - `req` must be held until `done` or `err`; dividers must be stable in the cycle before LOAD.
  - `req[i]` dropped while granted (LOAD, START or WAIT): abort. Go to FINISH with no pulse. The pointer still advances.
  - `req` still high after FINISH: re-arbitrated normally. A lone requester is re-granted 1 cycle after FINISH.
- **Timer pulses outside WAIT.** `tmr_it` is ignored in all states except WAIT. This includes any pulse the timer emits after its own reset or after an abort.
- **Simultaneous events.**
  - `tmr_it` and watchdog expiry in the same cycle: `done` wins.
  - `tmr_it` and `req` drop in the same cycle: abort wins, no pulse.
- **Reset mid-operation.** Asynchronous return to IDLE; all outputs drop immediately. No pulse is issued.

## Timing
- `req` rising in cycle n (FSM in IDLE) gives: `gnt` at n+1, LOAD during n+1, `tmr_start` high at n+2 and n+3, WAIT from n+4.
- The timer's 2-flop resync turns `tmr_start` into its internal start pulse about 2 cycles later. Expiry is then governed by the timer.
- `done`/`err` asserts the cycle after the WAIT exit condition and lasts exactly 1 cycle. `gnt` is low in that same cycle.
- Zero-divider error: `err` at n+2. No `tmr_start` is ever asserted.
- Minimum spacing between services: 1 IDLE cycle.

## Structure
- Package `timer_sched_pkg` holds:
  - the state enum (IDLE, LOAD, START, WAIT, FINISH);
  - `START_CYCLES` = 2;
  - the `done`/`err`/abort result encoding.
- Sub-module `rr_arbiter`: parameterised N, inputs `req` and `ptr`, one-hot `winner` output. It is combinational and reused elsewhere.
- The FSM, watchdog and divider registers live in `timer_sched`, which instantiates no timer. The integration top connects the `tmr_*` ports to `timer`.

## Test plan
- **Single request.** `req[2]`=1, divs (3,2), real timer attached → `gnt`=4'b0100 next cycle, `tmr_start` high exactly 2 cycles, one `done[2]` pulse, `err`=0.
- **Round-robin.** `req`=4'b1011 held throughout, each service completing normally → grant order 0,1,3,0,1.
- **Zero divider.** `req[1]` with `div_a`=0 → `err[1]` pulse 2 cycles after `req`, `tmr_start` never asserts.
- **Watchdog timeout.** Stub `tmr_it` tied to 0, WDOG_WIDTH=4 → `err[0]` pulse 15 cycles after WAIT entry, `tmr_enable` drops in the same cycle.
- **Abort and collisions.** Drop `req[3]` in WAIT → no pulse, IDLE next cycle. Spurious `tmr_it` in IDLE → ignored. `tmr_it` coinciding with watchdog expiry → `done`.
- **Reset mid-service.** `rstb` low during START → all outputs 0 asynchronously. After release, requester 0 wins first.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and constants for the timer scheduler.
package timer_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Number of cycles tmr_start is held high, so the timer's resync flops
    // are guaranteed to see it.
    localparam int START_CYCLES = 2;
    localparam int START_CNT_W  = 2;

    // Outcome of a service, decided on the cycle the FSM enters FINISH.
    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_DONE  = 2'd1,
        RES_ERR   = 2'd2,
        RES_ABORT = 2'd3
    } result_t;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The search starts one slot
// after ptr and wraps, so the last-served requester has lowest priority.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk ptr+1 .. ptr+N (mod N) and keep the first requester found.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin sharing of one two-stage timer among N_REQ
// requesters, with watchdog and per-requester done/err pulses.
//
// Handshake: a requester raises req[i] and holds it (with stable dividers)
// until it sees done[i] or err[i]; gnt[i] is high from LOAD until the cycle
// before the pulse. Dropping req[i] while granted aborts the service silently.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int A_WIDTH    = 4,
    parameter int B_WIDTH    = 4,
    parameter int WDOG_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*A_WIDTH-1:0]   req_div_a,
    input  logic [N_REQ*B_WIDTH-1:0]   req_div_b,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           err,
    output logic                       busy,
    output logic                       tmr_enable,
    output logic                       tmr_start,
    output logic [A_WIDTH-1:0]         tmr_div_a,
    output logic [B_WIDTH-1:0]         tmr_div_b,
    input  logic                       tmr_it
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);
    // Exit one count early so WAIT lasts exactly 2^WDOG_WIDTH-1 cycles.
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = {{(WDOG_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [START_CNT_W-1:0] START_LAST = START_CNT_W'(START_CYCLES - 1);

    state_t                  state_q;
    state_t                  state_d;
    result_t                 result;
    logic [PW-1:0]           ptr_q;
    logic [PW-1:0]           gnt_idx;
    logic [N_REQ-1:0]        winner;
    logic [A_WIDTH-1:0]      sel_div_a;
    logic [B_WIDTH-1:0]      sel_div_b;
    logic [START_CNT_W-1:0]  start_cnt;
    logic [WDOG_WIDTH-1:0]   wdog;
    logic                    lost_req;
    logic                    zero_div;
    logic                    wdog_expired;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner)
    );

    // Route the winner's dividers and encode the current grant as an index.
    always_comb begin
        sel_div_a = '0;
        sel_div_b = '0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                sel_div_a = req_div_a[i*A_WIDTH +: A_WIDTH];
                sel_div_b = req_div_b[i*B_WIDTH +: B_WIDTH];
            end
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    assign lost_req     = ((req & gnt) == '0);
    assign zero_div     = (tmr_div_a == '0) || (tmr_div_b == '0);
    assign wdog_expired = (wdog == WDOG_LAST);

    // Next-state and service outcome; abort beats done, done beats timeout.
    always_comb begin
        state_d = state_q;
        result  = RES_NONE;
        case (state_q)
            IDLE: begin
                if (|req) state_d = LOAD;
            end
            LOAD: begin
                if (lost_req) begin
                    state_d = FINISH;
                    result  = RES_ABORT;
                end else if (zero_div) begin
                    state_d = FINISH;
                    result  = RES_ERR;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                if (lost_req) begin
                    state_d = FINISH;
                    result  = RES_ABORT;
                end else if (start_cnt == START_LAST) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lost_req) begin
                    state_d = FINISH;
                    result  = RES_ABORT;
                end else if (tmr_it) begin
                    state_d = FINISH;
                    result  = RES_DONE;
                end else if (wdog_expired) begin
                    state_d = FINISH;
                    result  = RES_ERR;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Registered outputs, counters and round-robin pointer.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            busy       <= 1'b0;
            tmr_enable <= 1'b0;
            tmr_start  <= 1'b0;
            tmr_div_a  <= '0;
            tmr_div_b  <= '0;
            start_cnt  <= '0;
            wdog       <= '0;
            ptr_q      <= PTR_RST;
        end else begin
            done <= '0;
            err  <= '0;
            busy <= (state_d != IDLE);

            // Grant and capture the winner's dividers on leaving IDLE.
            if (state_q == IDLE && state_d == LOAD) begin
                gnt        <= winner;
                tmr_div_a  <= sel_div_a;
                tmr_div_b  <= sel_div_b;
                tmr_enable <= 1'b1;
            end

            if (state_q == LOAD && state_d == START) begin
                tmr_start <= 1'b1;
                start_cnt <= '0;
            end

            if (state_q == START) begin
                start_cnt <= start_cnt + 1'b1;
            end

            if (state_q == START && state_d == WAIT) begin
                tmr_start <= 1'b0;
                wdog      <= '0;
            end

            if (state_q == WAIT) begin
                wdog <= wdog + 1'b1;
            end

            // FINISH is only ever entered from LOAD/START/WAIT, so this fires
            // once per service.
            if (state_d == FINISH) begin
                gnt        <= '0;
                tmr_enable <= 1'b0;
                tmr_start  <= 1'b0;
                ptr_q      <= gnt_idx;
                if (result == RES_DONE) done <= gnt;
                if (result == RES_ERR)  err  <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed bench for timer_sched with a behavioural timer
// model and a stub tmr_it source; results are scoreboarded as {err, done}.
module tb_timer_sched;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int BW = 4;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rstb;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_div_a;
    logic [N*BW-1:0] req_div_b;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic            busy;
    logic            tmr_enable;
    logic            tmr_start;
    logic [AW-1:0]   tmr_div_a;
    logic [BW-1:0]   tmr_div_b;
    logic            tmr_it;

    logic            use_stub;
    logic            stub_it;
    logic            model_it;

    int              compared   = 0;
    int              mismatched = 0;
    int              exp_pulses = 0;
    int              pulse_total = 0;
    int              start_hi_total = 0;
    int              s0;
    logic [2*N-1:0]  exp_q[$];
    logic [N-1:0]    rr_order [5];

    assign tmr_it = use_stub ? stub_it : model_it;

    timer_sched #(
        .N_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .WDOG_WIDTH(WW)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .req        (req),
        .req_div_a  (req_div_a),
        .req_div_b  (req_div_b),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .tmr_enable (tmr_enable),
        .tmr_start  (tmr_start),
        .tmr_div_a  (tmr_div_a),
        .tmr_div_b  (tmr_div_b),
        .tmr_it     (tmr_it)
    );

    // Clock.
    always #5 clk = ~clk;

    // Behavioural timer: 2-flop start resync, then div_a * div_b cycles.
    logic [2:0]    sync;
    logic [AW-1:0] cnt_a;
    logic [BW-1:0] cnt_b;
    logic          running;
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync     <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            running  <= 1'b0;
            model_it <= 1'b0;
        end else begin
            sync     <= {sync[1:0], tmr_start};
            model_it <= 1'b0;
            if (!tmr_enable) begin
                running <= 1'b0;
            end else if (sync[1] && !sync[2]) begin
                cnt_a   <= tmr_div_a;
                cnt_b   <= tmr_div_b;
                running <= 1'b1;
            end else if (running) begin
                if (cnt_a <= 1) begin
                    cnt_a <= tmr_div_a;
                    if (cnt_b <= 1) begin
                        model_it <= 1'b1;
                        running  <= 1'b0;
                    end else begin
                        cnt_b <= cnt_b - 1'b1;
                    end
                end else begin
                    cnt_a <= cnt_a - 1'b1;
                end
            end
        end
    end

    // Free-running counts of tmr_start-high cycles and result pulses.
    always @(negedge clk) begin
        if (tmr_start) start_hi_total <= start_hi_total + 1;
        if (|done || |err) pulse_total <= pulse_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_div(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_div_a[i*AW +: AW] = a;
        req_div_b[i*BW +: BW] = b;
    endtask

    task automatic expect_result(input logic [N-1:0] e_err, input logic [N-1:0] e_done);
        exp_q.push_back({e_err, e_done});
        exp_pulses++;
    endtask

    // Wait (bounded) for a done/err pulse, then pop and compare.
    task automatic wait_pulse(input string tag, input int max_cyc);
        logic           seen;
        logic [2*N-1:0] exp;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            if (|done || |err) seen = 1'b1;
        end
        check({tag, " pulse seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " queued"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check({tag, " result"}, 32'({err, done}), 32'(exp));
                check({tag, " gnt low"}, 32'(gnt), 32'd0);
            end
        end
    endtask

    // Wait (bounded) for a grant and compare it.
    task automatic wait_gnt(input string tag, input int max_cyc, input logic [N-1:0] exp);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            if (|gnt) seen = 1'b1;
        end
        check({tag, " gnt seen"}, 32'(seen), 32'd1);
        check({tag, " gnt"}, 32'(gnt), 32'(exp));
    endtask

    initial begin
        rstb      = 1'b0;
        req       = '0;
        req_div_a = '0;
        req_div_b = '0;
        use_stub  = 1'b0;
        stub_it   = 1'b0;
        rr_order  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};

        // Reset values.
        step(2);
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst tmr_enable", 32'(tmr_enable), 32'd0);
        check("rst tmr_start", 32'(tmr_start), 32'd0);
        check("rst tmr_div_a", 32'(tmr_div_a), 32'd0);
        check("rst tmr_div_b", 32'(tmr_div_b), 32'd0);
        rstb = 1'b1;
        step(2);

        // Round-robin with 1011 held: order 0,1,3,0,1 from reset pointer.
        set_div(0, 4'd2, 4'd1);
        set_div(1, 4'd1, 4'd2);
        set_div(3, 4'd1, 4'd1);
        req = 4'b1011;
        for (int k = 0; k < 5; k++) expect_result(4'b0000, rr_order[k]);
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr", 8, rr_order[k]);
            wait_pulse("rr", 40);
        end
        req = '0;
        step(3);

        // Single request, real timer model.
        s0 = start_hi_total;
        set_div(2, 4'd3, 4'd2);
        req = 4'b0100;
        expect_result(4'b0000, 4'b0100);
        step(1);
        check("single gnt", 32'(gnt), 32'b0100);
        check("single busy", 32'(busy), 32'd1);
        check("single start n+1", 32'(tmr_start), 32'd0);
        step(1);
        check("single start n+2", 32'(tmr_start), 32'd1);
        check("single div_a", 32'(tmr_div_a), 32'd3);
        check("single div_b", 32'(tmr_div_b), 32'd2);
        check("single enable", 32'(tmr_enable), 32'd1);
        step(1);
        check("single start n+3", 32'(tmr_start), 32'd1);
        step(1);
        check("single start n+4", 32'(tmr_start), 32'd0);
        wait_pulse("single", 40);
        req = '0;
        step(3);
        check("single start cycles", 32'(start_hi_total - s0), 32'd2);

        // Zero divider: err two cycles after req, timer never started.
        s0 = start_hi_total;
        set_div(1, 4'd0, 4'd5);
        req = 4'b0010;
        expect_result(4'b0010, 4'b0000);
        step(1);
        check("zdiv gnt", 32'(gnt), 32'b0010);
        wait_pulse("zdiv", 1);
        check("zdiv enable", 32'(tmr_enable), 32'd0);
        req = '0;
        step(3);
        check("zdiv no start", 32'(start_hi_total - s0), 32'd0);

        // Watchdog timeout with tmr_it stuck low.
        use_stub = 1'b1;
        set_div(0, 4'd1, 4'd1);
        req = 4'b0001;
        expect_result(4'b0001, 4'b0000);
        step(1);
        check("wdog gnt", 32'(gnt), 32'b0001);
        step(3);
        check("wdog wait entry start", 32'(tmr_start), 32'd0);
        step(14);
        check("wdog err early", 32'(err), 32'd0);
        check("wdog enable held", 32'(tmr_enable), 32'd1);
        wait_pulse("wdog", 1);
        check("wdog enable drop", 32'(tmr_enable), 32'd0);
        req = '0;
        step(3);

        // tmr_it coinciding with watchdog expiry: done wins.
        req = 4'b0001;
        expect_result(4'b0000, 4'b0001);
        step(18);
        stub_it = 1'b1;
        wait_pulse("it_vs_wdog", 1);
        stub_it = 1'b0;
        req = '0;
        step(3);

        // Abort in WAIT with a coincident tmr_it: no pulse, pointer to 3.
        set_div(3, 4'd2, 4'd2);
        req = 4'b1000;
        step(1);
        check("abort gnt", 32'(gnt), 32'b1000);
        step(6);
        req     = '0;
        stub_it = 1'b1;
        step(1);
        stub_it = 1'b0;
        check("abort done", 32'(done), 32'd0);
        check("abort err", 32'(err), 32'd0);
        check("abort gnt low", 32'(gnt), 32'd0);
        check("abort enable", 32'(tmr_enable), 32'd0);
        step(1);
        check("abort idle", 32'(busy), 32'd0);

        // Pointer advanced past 3, so requester 0 beats 3.
        req = 4'b1001;
        expect_result(4'b0000, 4'b0001);
        step(1);
        check("post-abort gnt", 32'(gnt), 32'b0001);
        step(5);
        stub_it = 1'b1;
        wait_pulse("post-abort", 1);
        stub_it = 1'b0;
        req = '0;
        step(2);

        // Spurious tmr_it while idle is ignored.
        stub_it = 1'b1;
        step(1);
        stub_it = 1'b0;
        step(3);
        check("spurious busy", 32'(busy), 32'd0);
        check("spurious gnt", 32'(gnt), 32'd0);

        // Reset during START drops all outputs at once; requester 0 wins after.
        set_div(2, 4'd3, 4'd3);
        req = 4'b0100;
        step(1);
        check("rstmid gnt", 32'(gnt), 32'b0100);
        step(1);
        check("rstmid in start", 32'(tmr_start), 32'd1);
        rstb = 1'b0;
        #1;
        check("rstmid gnt", 32'(gnt), 32'd0);
        check("rstmid tmr_start", 32'(tmr_start), 32'd0);
        check("rstmid tmr_enable", 32'(tmr_enable), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid div_a", 32'(tmr_div_a), 32'd0);
        step(2);
        rstb = 1'b1;
        set_div(0, 4'd1, 4'd1);
        req = 4'b0101;
        expect_result(4'b0000, 4'b0001);
        step(1);
        check("rstmid first winner", 32'(gnt), 32'b0001);
        step(4);
        stub_it = 1'b1;
        wait_pulse("rstmid", 1);
        stub_it = 1'b0;
        req = '0;
        step(3);

        // Every expected result consumed, and no extra pulses anywhere.
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        check("pulse count", 32'(pulse_total), 32'(exp_pulses));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
